pwm_ramp_scheduler: RTL and testbench
=====================================

Name: pwm_ramp_scheduler

Overview:
Sequences width updates for the two motor PWM generators (left/right).
- Takes target widths from the peripheral write path.
- Slews each channel's applied width toward its target by a bounded step, once per 20 ms PWM frame.
- Forces both channels to neutral when commands stop arriving (watchdog failsafe) or when the drive is disabled.
- Sits between the bus register file and the PWM generators' width inputs.

Parameters:
- STEP, 4: maximum change in applied width per frame (1..255).
- NEUTRAL, 127: failsafe/disable/reset width.
- TIMEOUT_FRAMES, 25: frames without a write before failsafe (1..255); 25 frames = 500 ms.

Ports:
- clk_12MHz  input  1  system clock.
- reset  input  1  synchronous, active-high reset.
- enable  input  1  drive enable; low = hard stop to NEUTRAL.
- frame_tick  input  1  one-cycle pulse at the start of each PWM frame.
- wr_en  input  1  one-cycle write strobe for a target.
- wr_chan  input  1  channel select: 0 = left, 1 = right.
- wr_data  input  8  target width.
- width_left  output  8  applied width to the left PWM generator.
- width_right  output  8  applied width to the right PWM generator.
- failsafe  output  1  high while in FAILSAFE state.
- busy  output  1  high when either applied width differs from its target.

Behaviour:
- All state registered on posedge clk_12MHz. Reset is synchronous and active-high, sampled every edge, and overrides everything.
- Reset values:
  - width_left = width_right = NEUTRAL.
  - Targets = NEUTRAL.
  - failsafe = 0, busy = 0.
  - Watchdog counter = 0.
  - State = DISABLED if enable = 0, else RUN.
- States:
  - RUN: writes accepted; watchdog counts.
  - FAILSAFE: both targets held at NEUTRAL; ramping continues toward NEUTRAL.
  - DISABLED: widths and targets forced to NEUTRAL every cycle; writes and frame_tick ignored; counter held at 0.
- Transitions:
  - Any state -> DISABLED: when enable = 0, effective the next cycle, so widths are NEUTRAL on the following cycle (no ramp).
  - DISABLED -> RUN: when enable = 1. Counter restarts at 0.
  - RUN -> FAILSAFE: on the frame_tick where the incremented counter reaches TIMEOUT_FRAMES. Both targets are set to NEUTRAL in that same cycle.
  - FAILSAFE -> RUN: on any wr_en. The written target is stored; the other target stays at NEUTRAL.
- Writes (RUN or FAILSAFE):
  - The target for wr_chan becomes wr_data on the next edge.
  - The watchdog counter clears to 0.
  - A write in the same cycle as the timeout frame_tick wins: no failsafe entry, counter = 0.
- Ramp: on each frame_tick in RUN or FAILSAFE, each channel moves independently:
  - diff = target - applied, computed as signed 9-bit.
  - If |diff| <= STEP, applied = target.
  - Otherwise applied moves STEP toward target.
  - No wrap-around: applied is never below 0 or above 255.
  - The step uses the target value present before the edge. A write coinciding with frame_tick affects the next frame only.
- Watchdog:
  - Increments on frame_tick in RUN; saturates at TIMEOUT_FRAMES.
  - Does not count in FAILSAFE or DISABLED.
- Outputs:
  - width_left and width_right are registered and change only on a frame_tick, on entry to DISABLED, or on reset.
  - busy is combinational: (width_left != target_left) | (width_right != target_right). It is 0 in DISABLED.
- Latency:
  - Write to first width change: next frame_tick strictly after the write edge.
  - Full swing 0 -> 255 at STEP = 4: 64 frames.

Test Plan:
1. Reset with enable = 1, no writes -> widths = 127, failsafe = 0, busy = 0. After 25 frame_ticks, failsafe = 1 and widths stay at 127.
2. Write left = 255, then 40 frame_ticks, with one write every 10 frames to feed the watchdog -> width_left goes 131, 135, … and reaches 255 on the 32nd tick (last step 4). busy deasserts the same cycle. width_right stays 127.
3. Write right = 0 and left = 130, then one frame_tick -> right = 123 and left = 130 (|diff| 3 <= STEP, snaps to target). Subsequent ticks take right down to 0 with no wrap below 0.
4. Set left = 200 and ramp to it, then stop writing for 25 ticks -> failsafe asserts on the 25th tick. Afterwards left ramps 196, 192, … and reaches 127 after 19 ticks. A write of left = 150 clears failsafe with the counter at 0.
5. Ramp left toward 255, then drop enable mid-ramp -> the next cycle widths = 127 and failsafe = 0. A write while disabled is ignored. Raise enable: widths remain 127 until a new write.
6. Apply a write coincident with the 25th timeout frame_tick -> failsafe stays 0, the counter resets, and the new target is used from the following tick. Also assert reset mid-ramp -> widths = 127 on the next edge.

Source files
------------

// File: rtl/pwm_ramp_scheduler_if.sv
// Bundle between the bus register file and the ramp scheduler: control and
// write strobes in, applied PWM widths and status out.
interface pwm_ramp_scheduler_if;
    logic       enable;
    logic       frame_tick;
    logic       wr_en;
    logic       wr_chan;
    logic [7:0] wr_data;
    logic [7:0] width_left;
    logic [7:0] width_right;
    logic       failsafe;
    logic       busy;

    modport master (
        output enable, frame_tick, wr_en, wr_chan, wr_data,
        input  width_left, width_right, failsafe, busy
    );

    modport slave (
        input  enable, frame_tick, wr_en, wr_chan, wr_data,
        output width_left, width_right, failsafe, busy
    );
endinterface

// File: rtl/pwm_ramp_scheduler.sv
// Slews left/right PWM widths toward their targets once per frame, with a
// command watchdog that falls back to NEUTRAL and a hard stop on disable.
module pwm_ramp_scheduler #(
    parameter int STEP           = 4,
    parameter int NEUTRAL        = 127,
    parameter int TIMEOUT_FRAMES = 25
) (
    input  logic                 clk_12MHz,
    input  logic                 reset,
    pwm_ramp_scheduler_if.slave  bus
);
    typedef enum logic [1:0] {
        ST_RUN      = 2'd0,
        ST_FAILSAFE = 2'd1,
        ST_DISABLED = 2'd2
    } state_t;

    localparam logic [7:0]        NEUTRAL_W = 8'(NEUTRAL);
    localparam logic [7:0]        STEP_W    = 8'(STEP);
    localparam logic signed [8:0] STEP_S    = 9'(STEP);
    localparam logic [7:0]        TIMEOUT_W = 8'(TIMEOUT_FRAMES);

    state_t     state_q, state_d;
    logic [7:0] width_left_q, width_left_d;
    logic [7:0] width_right_q, width_right_d;
    logic [7:0] tgt_left_q, tgt_left_d;
    logic [7:0] tgt_right_q, tgt_right_d;
    logic [7:0] wdog_q, wdog_d;
    logic [7:0] wdog_inc;

    // |diff| > STEP guarantees the step stays inside 0..255, so no clamp needed.
    function automatic logic [7:0] ramp(input logic [7:0] applied, input logic [7:0] target);
        logic signed [8:0] diff;
        diff = $signed({1'b0, target}) - $signed({1'b0, applied});
        if (diff > STEP_S)
            ramp = applied + STEP_W;
        else if (diff < -STEP_S)
            ramp = applied - STEP_W;
        else
            ramp = target;
    endfunction

    always_ff @(posedge clk_12MHz) begin
        if (reset) begin
            state_q       <= bus.enable ? ST_RUN : ST_DISABLED;
            width_left_q  <= NEUTRAL_W;
            width_right_q <= NEUTRAL_W;
            tgt_left_q    <= NEUTRAL_W;
            tgt_right_q   <= NEUTRAL_W;
            wdog_q        <= 8'd0;
        end else begin
            state_q       <= state_d;
            width_left_q  <= width_left_d;
            width_right_q <= width_right_d;
            tgt_left_q    <= tgt_left_d;
            tgt_right_q   <= tgt_right_d;
            wdog_q        <= wdog_d;
        end
    end

    always_comb begin
        state_d       = state_q;
        width_left_d  = width_left_q;
        width_right_d = width_right_q;
        tgt_left_d    = tgt_left_q;
        tgt_right_d   = tgt_right_q;
        wdog_d        = wdog_q;
        wdog_inc      = (wdog_q >= TIMEOUT_W) ? TIMEOUT_W : wdog_q + 8'd1;

        if (!bus.enable) begin
            // Hard stop: no ramp, neutral immediately.
            state_d       = ST_DISABLED;
            width_left_d  = NEUTRAL_W;
            width_right_d = NEUTRAL_W;
            tgt_left_d    = NEUTRAL_W;
            tgt_right_d   = NEUTRAL_W;
            wdog_d        = 8'd0;
        end else if (state_q == ST_DISABLED) begin
            state_d       = ST_RUN;
            width_left_d  = NEUTRAL_W;
            width_right_d = NEUTRAL_W;
            tgt_left_d    = NEUTRAL_W;
            tgt_right_d   = NEUTRAL_W;
            wdog_d        = 8'd0;
        end else begin
            // Ramp uses the targets held before this edge; a coincident write lands next frame.
            if (bus.frame_tick) begin
                width_left_d  = ramp(width_left_q, tgt_left_q);
                width_right_d = ramp(width_right_q, tgt_right_q);
            end
            if (bus.wr_en) begin
                if (bus.wr_chan)
                    tgt_right_d = bus.wr_data;
                else
                    tgt_left_d = bus.wr_data;
                wdog_d  = 8'd0;
                state_d = ST_RUN;
            end else if (state_q == ST_RUN && bus.frame_tick) begin
                wdog_d = wdog_inc;
                if (wdog_inc == TIMEOUT_W) begin
                    state_d     = ST_FAILSAFE;
                    tgt_left_d  = NEUTRAL_W;
                    tgt_right_d = NEUTRAL_W;
                end
            end
        end
    end

    assign bus.width_left  = width_left_q;
    assign bus.width_right = width_right_q;
    assign bus.failsafe    = (state_q == ST_FAILSAFE);
    assign bus.busy        = (state_q != ST_DISABLED) &&
                             ((width_left_q != tgt_left_q) || (width_right_q != tgt_right_q));
endmodule

// File: tb/tb_pwm_ramp_scheduler.sv
// Directed bench for the PWM ramp scheduler: reset, ramps, watchdog failsafe,
// disable, coincident write/timeout and mid-ramp reset.
module tb_pwm_ramp_scheduler;
    logic clk;
    logic reset;
    int   checks;
    int   errors;

    pwm_ramp_scheduler_if bus ();

    pwm_ramp_scheduler dut (
        .clk_12MHz (clk),
        .reset     (reset),
        .bus       (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic tick();
        bus.frame_tick = 1'b1;
        @(negedge clk);
        bus.frame_tick = 1'b0;
    endtask

    task automatic write(input logic ch, input logic [7:0] data);
        bus.wr_en   = 1'b1;
        bus.wr_chan = ch;
        bus.wr_data = data;
        @(negedge clk);
        bus.wr_en   = 1'b0;
    endtask

    task automatic write_tick(input logic ch, input logic [7:0] data);
        bus.frame_tick = 1'b1;
        bus.wr_en      = 1'b1;
        bus.wr_chan    = ch;
        bus.wr_data    = data;
        @(negedge clk);
        bus.frame_tick = 1'b0;
        bus.wr_en      = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    initial begin
        checks         = 0;
        errors         = 0;
        reset          = 1'b1;
        bus.enable     = 1'b1;
        bus.frame_tick = 1'b0;
        bus.wr_en      = 1'b0;
        bus.wr_chan    = 1'b0;
        bus.wr_data    = 8'd0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;

        // 1: reset state, then watchdog timeout with no writes
        chk("rst_left", bus.width_left, 127);
        chk("rst_right", bus.width_right, 127);
        chk("rst_failsafe", bus.failsafe, 0);
        chk("rst_busy", bus.busy, 0);
        for (int n = 1; n <= 25; n++) begin
            tick();
            chk("s1_failsafe", bus.failsafe, (n == 25) ? 1 : 0);
        end
        chk("s1_left", bus.width_left, 127);
        chk("s1_right", bus.width_right, 127);

        // 2: ramp left up to 255, feeding the watchdog every 10 frames
        write(1'b0, 8'd255);
        chk("s2_failsafe_clr", bus.failsafe, 0);
        chk("s2_busy_start", bus.busy, 1);
        for (int n = 1; n <= 40; n++) begin
            tick();
            chk("s2_left", bus.width_left, (n >= 32) ? 255 : 127 + 4 * n);
            chk("s2_busy", bus.busy, (n >= 32) ? 0 : 1);
            if (n % 10 == 0) write(1'b0, 8'd255);
        end
        chk("s2_right", bus.width_right, 127);
        chk("s2_failsafe", bus.failsafe, 0);

        // 3: snap-to-target and ramp down to 0 without wrap
        do_reset();
        write(1'b1, 8'd0);
        write(1'b0, 8'd130);
        tick();
        chk("s3_right_first", bus.width_right, 123);
        chk("s3_left_snap", bus.width_left, 130);
        for (int n = 2; n <= 33; n++) begin
            tick();
            chk("s3_right", bus.width_right, (n >= 32) ? 0 : 127 - 4 * n);
            if (n == 20) write(1'b0, 8'd130);
        end
        chk("s3_left_hold", bus.width_left, 130);

        // 4: ramp left to 200, starve the watchdog, ramp back to neutral
        write(1'b0, 8'd200);
        for (int n = 1; n <= 18; n++) tick();
        chk("s4_left_200", bus.width_left, 200);
        write(1'b0, 8'd200);
        for (int n = 1; n <= 25; n++) begin
            tick();
            chk("s4_timeout", bus.failsafe, (n == 25) ? 1 : 0);
        end
        chk("s4_left_at_fs", bus.width_left, 200);
        for (int n = 1; n <= 19; n++) begin
            tick();
            chk("s4_fs_left", bus.width_left, (n == 19) ? 127 : 200 - 4 * n);
            chk("s4_fs_right", bus.width_right, 4 * n);
            chk("s4_fs_held", bus.failsafe, 1);
        end
        write(1'b0, 8'd150);
        chk("s4_fs_exit", bus.failsafe, 0);
        for (int n = 1; n <= 25; n++) begin
            tick();
            chk("s4_run_left", bus.width_left, (n >= 6) ? 150 : 127 + 4 * n);
            chk("s4_run_right", bus.width_right, (n >= 13) ? 127 : 76 + 4 * n);
            chk("s4_cnt_restart", bus.failsafe, (n == 25) ? 1 : 0);
        end

        // 5: disable mid-ramp
        write(1'b0, 8'd255);
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("s5_left_ramp", bus.width_left, 150 + 4 * n);
        end
        bus.enable = 1'b0;
        @(negedge clk);
        chk("s5_dis_left", bus.width_left, 127);
        chk("s5_dis_right", bus.width_right, 127);
        chk("s5_dis_failsafe", bus.failsafe, 0);
        chk("s5_dis_busy", bus.busy, 0);
        write(1'b0, 8'd200);
        tick();
        tick();
        chk("s5_dis_wr_ignored", bus.width_left, 127);
        chk("s5_dis_busy2", bus.busy, 0);
        bus.enable = 1'b1;
        @(negedge clk);
        tick();
        tick();
        chk("s5_en_left", bus.width_left, 127);
        chk("s5_en_right", bus.width_right, 127);
        chk("s5_en_busy", bus.busy, 0);
        chk("s5_en_failsafe", bus.failsafe, 0);

        // 6: write coincident with the timeout tick wins
        write(1'b0, 8'd135);
        for (int n = 1; n <= 24; n++) begin
            tick();
            chk("s6_pre_left", bus.width_left, (n == 1) ? 131 : 135);
            chk("s6_pre_failsafe", bus.failsafe, 0);
        end
        write_tick(1'b0, 8'd100);
        chk("s6_coinc_failsafe", bus.failsafe, 0);
        chk("s6_coinc_left", bus.width_left, 135);
        chk("s6_coinc_busy", bus.busy, 1);
        for (int n = 1; n <= 25; n++) begin
            tick();
            chk("s6_left", bus.width_left, (n >= 9) ? 100 : 135 - 4 * n);
            chk("s6_cnt_cleared", bus.failsafe, (n == 25) ? 1 : 0);
        end

        // 6b: reset mid-ramp
        write(1'b0, 8'd200);
        for (int n = 1; n <= 3; n++) begin
            tick();
            chk("s6_ramp_up", bus.width_left, 100 + 4 * n);
        end
        do_reset();
        chk("s6_rst_left", bus.width_left, 127);
        chk("s6_rst_right", bus.width_right, 127);
        chk("s6_rst_busy", bus.busy, 0);
        chk("s6_rst_failsafe", bus.failsafe, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
